freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 146 ++++++++++++++
 tb/tb_freq_meter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of wave_in over a fixed gate window.
// Optional macro FREQ_METER_OVERFLOW_EN: saturating edge counter with a registered overflow flag.
module freq_meter #(
  parameter int unsigned GATE_CYCLES   = 50000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned COUNT_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wave_in,
  input  logic                   start,
  input  logic [4:0]             sel_in,
  output logic [4:0]             select_out,
  output logic                   mux_enable,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   valid,
  input  logic                   ack,
  output logic                   overflow
);

  localparam int unsigned TIMER_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW        = $clog2(TIMER_MAX);
  localparam logic [4:0]  MAX_SEL   = 5'd23;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t                 state, state_next;
  logic                   sync1, sync2, sync3;
  logic                   rise;
  logic [TW-1:0]          timer;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_cnt_next;
  logic                   accept, settle_done, gate_done, release_res;

  assign rise       = sync2 & ~sync3;
  assign busy       = (state != IDLE);
  assign mux_enable = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    settle_done = 1'b0;
    gate_done   = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (start && (sel_in <= MAX_SEL)) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          settle_done = 1'b1;
          state_next  = MEASURE;
        end
      end
      MEASURE: begin
        if (timer == '0) begin
          gate_done  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          release_res = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FREQ_METER_OVERFLOW_EN
  logic sat, sat_next;

  always_comb begin
    edge_cnt_next = edge_cnt;
    sat_next      = sat;
    if ((state == MEASURE) && rise) begin
      if (&edge_cnt) sat_next      = 1'b1;
      else           edge_cnt_next = edge_cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (settle_done)            sat <= 1'b0;
      else if (state == MEASURE)  sat <= sat_next;
      if (gate_done)              overflow <= sat_next;
    end
  end
`else
  always_comb begin
    edge_cnt_next = edge_cnt + COUNT_WIDTH'((state == MEASURE) && rise);
  end

  assign overflow = 1'b0;
`endif

  // The result takes edge_cnt_next so an edge detected in the last gate cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      timer      <= '0;
      edge_cnt   <= '0;
      select_out <= '0;
      count      <= '0;
      valid      <= 1'b0;
    end else begin
      sync1 <= wave_in;
      sync2 <= sync1;
      sync3 <= sync2;

      if (accept) begin
        select_out <= sel_in;
        timer      <= TW'(SETTLE_CYCLES - 1);
      end else if (settle_done) begin
        timer <= TW'(GATE_CYCLES - 1);
      end else if (((state == SETTLE) || (state == MEASURE)) && (timer != '0)) begin
        timer <= timer - TW'(1);
      end

      if (settle_done)            edge_cnt <= '0;
      else if (state == MEASURE)  edge_cnt <= edge_cnt_next;

      if (gate_done) begin
        count <= edge_cnt_next;
        valid <= 1'b1;
      end else if (release_res) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table of wave periods plus hand-written corner sequences.
module tb_freq_meter;

  localparam int unsigned G  = 200;
  localparam int unsigned S  = 16;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wave_in;
  logic          start;
  logic [4:0]    sel_in;
  logic [4:0]    select_out;
  logic          mux_enable;
  logic          busy;
  logic [CW-1:0] count;
  logic          valid;
  logic          ack;
  logic          overflow;

  freq_meter #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wave_in   (wave_in),
    .start     (start),
    .sel_in    (sel_in),
    .select_out(select_out),
    .mux_enable(mux_enable),
    .busy      (busy),
    .count     (count),
    .valid     (valid),
    .ack       (ack),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  bit gen_en = 1'b0;
  int half   = 1;
  int ph     = 0;

  always @(negedge clk) begin
    if (gen_en) begin
      ph++;
      if (ph >= half) begin
        ph      = 0;
        wave_in = ~wave_in;
      end
    end
  end

  typedef struct {
    logic [CW-1:0] c;
    logic          o;
  } res_t;

  typedef struct {
    int            half;
    logic [4:0]    sel;
    res_t          exp;
  } vec_t;

  res_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input int edges);
    res_t r;
`ifdef FREQ_METER_OVERFLOW_EN
    r.o = (edges > ((1 << CW) - 1));
    r.c = r.o ? '1 : CW'(edges);
`else
    r.o = 1'b0;
    r.c = CW'(edges % (1 << CW));
`endif
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_wave(input int h);
    gen_en = 1'b1;
    half   = h;
    ph     = 0;
    tick(10);
  endtask

  task automatic stop_wave();
    gen_en  = 1'b0;
    wave_in = 1'b0;
    tick(5);
  endtask

  task automatic do_start(input logic [4:0] s);
    start  = 1'b1;
    sel_in = s;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < int'(G + S + 50)) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic begin_meas(input string name, input logic [4:0] s, input res_t e);
    sb.push_back(e);
    do_start(s);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_mux_en"}, 32'(mux_enable), 32'd1);
    check({name, "_select"}, 32'(select_out), 32'(s));
  endtask

  task automatic finish_meas(input string name, input bit chk_lat, input bit do_ack);
    int   cyc;
    res_t e;
    wait_valid(cyc);
    check({name, "_valid_timeout"}, 32'(valid), 32'd1);
    if (chk_lat) check({name, "_latency"}, 32'(cyc + 1), 32'(G + S + 1));
    e = sb.pop_front();
    check({name, "_count"}, 32'(count), 32'(e.c));
    check({name, "_overflow"}, 32'(overflow), 32'(e.o));
    if (do_ack) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check({name, "_valid_cleared"}, 32'(valid), 32'd0);
      check({name, "_busy_cleared"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic single_edge(input string name, input int k, input int edges);
    stop_wave();
    begin_meas(name, 5'd2, model(edges));
    tick(k - 3);
    wave_in = 1'b1;
    tick(4);
    wave_in = 1'b0;
    finish_meas(name, 1'b0, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   seen;
    int   cyc;
    res_t e;

    rst     = 1'b1;
    wave_in = 1'b0;
    start   = 1'b0;
    sel_in  = '0;
    ack     = 1'b0;

    vecs[0] = '{half: 2,  sel: 5'd5,  exp: model(G / 4)};
    vecs[1] = '{half: 5,  sel: 5'd12, exp: model(G / 10)};
    vecs[2] = '{half: 10, sel: 5'd0,  exp: model(G / 20)};
    vecs[3] = '{half: 1,  sel: 5'd23, exp: model(G / 2)};
    vecs[4] = '{half: 25, sel: 5'd17, exp: model(G / 50)};
    vecs[5] = '{half: 20, sel: 5'd8,  exp: model(G / 40)};

    tick(2);
    check("rst_select", 32'(select_out), 32'd0);
    check("rst_mux_en", 32'(mux_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      set_wave(vecs[i].half);
      begin_meas($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp);
      finish_meas($sformatf("vec%0d", i), 1'b1, 1'b1);
    end

    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_valid", 32'(valid), 32'd0);

    do_start(5'd24);
    check("sel24_busy", 32'(busy), 32'd0);
    check("sel24_mux_en", 32'(mux_enable), 32'd0);
    check("sel24_select", 32'(select_out), 32'd8);

    // Result hold: valid stays up without ack, count frozen while the input changes.
    set_wave(5);
    sb.push_back(model(G / 10));
    do_start(5'd5);
    wait_valid(cyc);
    check("hold_valid_timeout", 32'(valid), 32'd1);
    e = sb.pop_front();
    check("hold_count", 32'(count), 32'(e.c));
    half = 2;
    tick(500);
    check("hold_count_after", 32'(count), 32'(e.c));
    check("hold_valid_after", 32'(valid), 32'd1);
    check("hold_busy_after", 32'(busy), 32'd1);
    ack    = 1'b1;
    start  = 1'b1;
    sel_in = 5'd7;
    @(negedge clk);
    ack    = 1'b0;
    start  = 1'b0;
    check("ackstart_valid", 32'(valid), 32'd0);
    check("ackstart_busy", 32'(busy), 32'd0);
    tick(2);
    check("ackstart_dropped", 32'(busy), 32'd0);
    check("ackstart_select", 32'(select_out), 32'd5);

    set_wave(10);
    begin_meas("midstart", 5'd3, model(G / 20));
    tick(50);
    start  = 1'b1;
    sel_in = 5'd9;
    @(negedge clk);
    start  = 1'b0;
    check("midstart_select", 32'(select_out), 32'd3);
    finish_meas("midstart", 1'b0, 1'b1);

    set_wave(5);
    do_start(5'd4);
    tick(100);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mux_en", 32'(mux_enable), 32'd0);
    check("midrst_select", 32'(select_out), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(G + S + 20); i++) begin
      @(negedge clk);
      seen = seen | valid;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    begin_meas("postrst", 5'd6, model(G / 10));
    finish_meas("postrst", 1'b1, 1'b1);

    stop_wave();
    begin_meas("settle_only", 5'd1, model(0));
    repeat (3) begin
      wave_in = 1'b1;
      tick(1);
      wave_in = 1'b0;
      tick(1);
    end
    finish_meas("settle_only", 1'b0, 1'b1);

    single_edge("edge_last_settle", S, 0);
    single_edge("edge_first_gate", S + 1, 1);
    single_edge("edge_final_gate", G + S, 1);
    single_edge("edge_after_gate", G + S + 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
